// File: rtl/seq_restoring_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider_pkg
// Shared definitions for the sequential restoring divider:
//   state_t          - controller states (IDLE / CALC / DONE)
//   DEFAULT_WIDTH    - default operand/result width
//   DEFAULT_CNT_W    - iteration counter width for DEFAULT_WIDTH
//   DBZ_QUOTIENT     - quotient reported on divide-by-zero (all ones)
//   cnt_width()      - iteration counter width for an arbitrary width
// -----------------------------------------------------------------------------
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

  localparam logic [DEFAULT_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage : seq_restoring_divider_pkg

// File: rtl/seq_restoring_divider_addsub_w.sv
// -----------------------------------------------------------------------------
// addsub_w
// N-bit ripple-carry adder/subtractor.
//   i_a, i_b : operands
//   i_m      : mode, 0 = a + b, 1 = a - b (b inverted, carry-in 1)
//   o_sum    : N-bit result
//   o_cout   : carry out of the top stage; in subtract mode 1 means no borrow
// -----------------------------------------------------------------------------
module addsub_w #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_m,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic [N:0]   w_carry;
  logic [N-1:0] w_b;

  assign w_carry[0] = i_m;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_fa
      assign w_b[gi]         = i_b[gi] ^ i_m;
      assign o_sum[gi]       = i_a[gi] ^ w_b[gi] ^ w_carry[gi];
      assign w_carry[gi + 1] = (i_a[gi] & w_b[gi]) | (w_carry[gi] & (i_a[gi] ^ w_b[gi]));
    end
  endgenerate

  assign o_cout = w_carry[N];

endmodule : addsub_w

// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
// Multi-cycle unsigned restoring divider with start/busy/done handshake.
// One quotient bit is resolved per clock; a WIDTH-bit divide takes WIDTH
// iteration cycles plus one DONE cycle. Divide-by-zero completes in one cycle.
//   i_clk         - clock, rising edge
//   i_rst_n       - asynchronous active-low reset
//   i_start       - request, sampled in IDLE or DONE only
//   i_dividend    - unsigned dividend, sampled with i_start
//   i_divisor     - unsigned divisor, sampled with i_start
//   o_busy        - high while iterating (state CALC)
//   o_done        - one-cycle completion pulse
//   o_quotient    - quotient, held until the next completion
//   o_remainder   - remainder, held until the next completion
//   o_div_by_zero - set with done when the divisor was zero
// -----------------------------------------------------------------------------
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;        // partial remainder; always < divisor between iterations
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH:0]   w_a_shift;
  logic [WIDTH-1:0] w_trial;
  logic             w_trial_msb;
  logic             w_cout;
  logic             w_take;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_q_next;

  // {A,Q} << 1 : the bit leaving Q enters A. The shifted A needs WIDTH+1 bits
  // because it can reach 2*D-1.
  assign w_a_shift = {r_a, r_q[WIDTH-1]};

  addsub_w #(
    .N (WIDTH + 1)
  ) u_trial_sub (
    .i_a    (w_a_shift),
    .i_b    ({1'b0, r_d}),
    .i_m    (1'b1),
    .o_sum  ({w_trial_msb, w_trial}),
    .o_cout (w_cout)
  );

  // No borrow means the trial difference is in [0, D), so its msb is clear;
  // a borrow makes the (WIDTH+1)-bit result negative with msb set. Both views
  // agree; the msb term just keeps the full adder result in use.
  assign w_take = w_cout & ~w_trial_msb;

  // On restore, the shifted A is already < D, so its low WIDTH bits are exact.
  assign w_a_next = w_take ? w_trial : w_a_shift[WIDTH-1:0];
  assign w_q_next = {r_q[WIDTH-2:0], w_take};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_a           <= '0;
      r_q           <= '0;
      r_d           <= '0;
      r_count       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // DONE accepts a new request exactly like IDLE, enabling back-to-back use.
        ST_IDLE, ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (i_start) begin
            if (i_divisor == '0) begin
              r_state       <= ST_DONE;
              r_done        <= 1'b1;
              r_quotient    <= '1;
              r_remainder   <= i_dividend;
              r_div_by_zero <= 1'b1;
            end else begin
              r_a     <= '0;
              r_q     <= i_dividend;
              r_d     <= i_divisor;
              r_count <= CNT_INIT;
              r_state <= ST_CALC;
              r_busy  <= 1'b1;
            end
          end
        end

        ST_CALC: begin
          r_a     <= w_a_next;
          r_q     <= w_q_next;
          r_count <= r_count - CNT_LAST;
          if (r_count == CNT_LAST) begin
            r_state       <= ST_DONE;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_quotient    <= w_q_next;
            r_remainder   <= w_a_next;
            r_div_by_zero <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;

endmodule : seq_restoring_divider
